serial_add_ctrl: RTL and testbench
==================================

# serial_add_ctrl

Bit-serial add sequencer that time-shares one full-adder cell across all bit positions of two WIDTH-bit operands, one bit per clock, LSB first. It sits between the switch inputs and the board's seven-segment display, replacing the ripple chain of parallel full adders with a single shared adder cell plus a controller. A start/busy/done handshake frames each addition. The controller drives the low result nibble to an active-low seven-segment decoder and the final carry to a separate output.

## Interface
- WIDTH, 4, operand width in bits; legal range 1..16.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  operand A; captured on the accepted start edge.
- b  in  WIDTH  operand B; captured on the accepted start edge.
- cin  in  1  carry-in; captured on the accepted start edge.
- busy  out  1  high while bits are being processed.
- done  out  1  one-cycle pulse when the result becomes valid.
- sum  out  WIDTH  registered sum bits.
- cout  out  1  registered final carry.
- seg  out  7  active-low segments {g,f,e,d,c,b,a} for the hex digit of the result's low 4 bits.

## Operation
- Reset values: state=IDLE; busy=0; done=0; sum=0; cout=0; internal shift registers, carry and bit counter all 0.
- Reset value of seg: 7'b1000000 (digit 0) with SERIAL_ADD_SEG_EN defined, 7'b1111111 without it.
- Shared adder cell: s = a_sh[0] ^ b_sh[0] ^ c; c_next = (a_sh[0] & b_sh[0]) | ((a_sh[0] ^ b_sh[0]) & c).
- IDLE:
  - If start=1, load a_sh=a, b_sh=b, c=cin, cnt=0, then go to RUN.
  - Otherwise hold all registers.
- RUN, one bit per cycle:
  - Shift s into the MSB of the result shift register; shift a_sh and b_sh right by 1.
  - Set c=c_next and cnt=cnt+1.
  - When cnt reaches WIDTH-1 on this cycle, go to DONE.
- DONE, one cycle:
  - Copy the result shift register to sum and c to cout.
  - Pulse done for exactly one cycle, then return to IDLE.
- The counter is $clog2(WIDTH+1) bits wide and never wraps within an operation.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1), unsigned.
- sum and cout hold their value until the next DONE; they are not cleared on start.
- start=1 while in RUN or DONE is ignored and is not queued.
- a, b and cin may change after the accepted start without effect on the operation in progress.
- start held high continuously causes back-to-back operations, with one IDLE cycle between them.

## Timing
- Start accepted at edge T0. busy=1 from T0 through T0+WIDTH, i.e. WIDTH cycles.
- done=1 for the single cycle after edge T0+WIDTH+1; sum, cout and seg are valid from that same edge.
- Total latency from start to done is WIDTH+1 cycles; the minimum start-to-start period is WIDTH+2 cycles.
- seg is a registered decode of the updated sum and changes on the same edge as sum.
- rst_n low mid-operation aborts immediately and asynchronously to the reset values above; no done is generated.
- After rst_n deasserts, the first start is accepted at the next clk edge.

## Configuration
- SERIAL_ADD_SEG_EN defined:
  - seg shows the hex digit of {zero-extended sum}[3:0].
  - Patterns 0-F: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
- SERIAL_ADD_SEG_EN undefined: the decoder logic is removed and seg is constant 7'b1111111 (all segments off). All other behaviour is unchanged.

## Test plan
- Reset: assert rst_n=0 mid-sim -> busy=0, done=0, sum=0, cout=0, seg=1000000 (macro defined).
- WIDTH=4, a=3, b=2, cin=0, start for 1 cycle -> busy for 4 cycles; done 5 cycles after start; sum=0101, cout=0, seg=0010010.
- a=4'hF, b=4'h1, cin=0 -> sum=0000, cout=1, seg=1000000.
- a=4'hF, b=4'hF, cin=1 -> sum=1111, cout=1, seg=0001110.
- Pulse start again 2 cycles into RUN with a=1, b=1 -> ignored; the result is from the original operands; exactly one done pulse.
- rst_n low at RUN cycle 2, then released and start applied with a=5, b=4 -> no done from the aborted operation; the new operation returns sum=1001, seg=0010000.

Source files
------------

// File: rtl/serial_add_ctrl_if.sv
// Start/busy/done handshake and operand/result bundle for the bit-serial adder.
interface serial_add_ctrl_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic [6:0]       seg;

   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout, seg
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout, seg
   );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one shared full-adder cell, LSB first, one bit per clock.
// Define SERIAL_ADD_SEG_EN to enable the active-low seven-segment decode of sum[3:0].
module serial_add_ctrl #(
   parameter int WIDTH = 4
) (
   input logic            clk,
   input logic            rst_n,
   serial_add_ctrl_if.slave bus
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] aSh_q, aSh_d;
   logic [WIDTH-1:0] bSh_q, bSh_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             c_q, c_d;
   logic             cout_q, cout_d;
   logic             done_q, done_d;
   logic             s, cNext;

   assign s     = aSh_q[0] ^ bSh_q[0] ^ c_q;
   assign cNext = (aSh_q[0] & bSh_q[0]) | ((aSh_q[0] ^ bSh_q[0]) & c_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         aSh_q   <= '0;
         bSh_q   <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         c_q     <= 1'b0;
         cout_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         aSh_q   <= aSh_d;
         bSh_q   <= bSh_d;
         res_q   <= res_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         c_q     <= c_d;
         cout_q  <= cout_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = RUN;
         RUN:     if (cnt_q == LAST) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // done is registered so it rises on the same edge that publishes sum/cout/seg.
   always_comb begin
      aSh_d  = aSh_q;
      bSh_d  = bSh_q;
      res_d  = res_q;
      sum_d  = sum_q;
      cnt_d  = cnt_q;
      c_d    = c_q;
      cout_d = cout_q;
      done_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               aSh_d = bus.a;
               bSh_d = bus.b;
               c_d   = bus.cin;
               cnt_d = '0;
            end
         end
         RUN: begin
            res_d            = res_q >> 1;
            res_d[WIDTH-1]   = s;
            aSh_d            = aSh_q >> 1;
            bSh_d            = bSh_q >> 1;
            c_d              = cNext;
            cnt_d            = cnt_q + CW'(1);
         end
         DONE: begin
            sum_d  = res_q;
            cout_d = c_q;
            done_d = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.busy = (state_q == RUN);
   assign bus.done = done_q;
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;

`ifdef SERIAL_ADD_SEG_EN
   logic [6:0] seg_q, seg_d;
   logic [3:0] nibble;

   assign nibble = 4'(res_q);

   always_comb begin
      seg_d = seg_q;
      if (state_q == DONE) begin
         case (nibble)
            4'h0: seg_d = 7'b1000000;
            4'h1: seg_d = 7'b1111001;
            4'h2: seg_d = 7'b0100100;
            4'h3: seg_d = 7'b0110000;
            4'h4: seg_d = 7'b0011001;
            4'h5: seg_d = 7'b0010010;
            4'h6: seg_d = 7'b0000010;
            4'h7: seg_d = 7'b1111000;
            4'h8: seg_d = 7'b0000000;
            4'h9: seg_d = 7'b0010000;
            4'hA: seg_d = 7'b0001000;
            4'hB: seg_d = 7'b0000011;
            4'hC: seg_d = 7'b1000110;
            4'hD: seg_d = 7'b0100001;
            4'hE: seg_d = 7'b0000110;
            default: seg_d = 7'b0001110;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) seg_q <= 7'b1000000;
      else        seg_q <= seg_d;
   end

   assign bus.seg = seg_q;
`else
   assign bus.seg = 7'b1111111;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl (WIDTH=4); seg expectations follow SERIAL_ADD_SEG_EN.
module tb_serial_add_ctrl;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   int   edgeN;
   int   busyCount;
   int   doneCount;
   int   doneEdge;

   serial_add_ctrl_if #(.WIDTH(4)) bus ();

   serial_add_ctrl #(.WIDTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [6:0] segExp(input logic [6:0] lit);
`ifdef SERIAL_ADD_SEG_EN
      return lit;
`else
      return 7'b1111111;
`endif
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      edgeN++;
      busyCount += int'(bus.busy);
      if (bus.done) begin
         doneCount++;
         if (doneEdge < 0) doneEdge = edgeN;
      end
   endtask

   // Called #1 after a posedge; returns #1 after the accepting edge T0 with start dropped.
   task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic cin);
      bus.start = 1'b1;
      bus.a     = a;
      bus.b     = b;
      bus.cin   = cin;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      edgeN     = 0;
      busyCount = int'(bus.busy);
      doneCount = 0;
      doneEdge  = -1;
   endtask

   task automatic waitDone();
      while (doneEdge < 0 && edgeN < 20) tick();
   endtask

   task automatic checkResult(input string tag, input logic [3:0] expSum, input logic expCout, input logic [6:0] expSeg);
      checkOutput({tag, "_latency"}, 32'(doneEdge), 32'd5);
      checkOutput({tag, "_busy"}, 32'(busyCount), 32'd4);
      checkOutput({tag, "_sum"}, 32'(bus.sum), 32'(expSum));
      checkOutput({tag, "_cout"}, 32'(bus.cout), 32'(expCout));
      checkOutput({tag, "_seg"}, 32'(bus.seg), 32'(segExp(expSeg)));
      tick();
      checkOutput({tag, "_donePulse"}, 32'(bus.done), 32'd0);
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      edgeN     = 0;
      busyCount = 0;
      doneCount = 0;
      doneEdge  = -1;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.cin   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_busy", 32'(bus.busy), 32'd0);
      checkOutput("rst_done", 32'(bus.done), 32'd0);
      checkOutput("rst_sum", 32'(bus.sum), 32'd0);
      checkOutput("rst_seg", 32'(bus.seg), 32'(segExp(7'b1000000)));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      applyStimulus(4'd3, 4'd2, 1'b0);
      checkOutput("t1_busyAtT0", 32'(bus.busy), 32'd1);
      waitDone();
      checkResult("t1", 4'b0101, 1'b0, 7'b0010010);

      applyStimulus(4'hF, 4'h1, 1'b0);
      waitDone();
      checkResult("t2", 4'b0000, 1'b1, 7'b1000000);

      applyStimulus(4'hF, 4'hF, 1'b1);
      waitDone();
      checkResult("t3", 4'b1111, 1'b1, 7'b0001110);

      // Start pulsed mid-run with new operands must be ignored.
      applyStimulus(4'd6, 4'd7, 1'b0);
      tick();
      bus.start = 1'b1;
      bus.a     = 4'd1;
      bus.b     = 4'd1;
      tick();
      bus.start = 1'b0;
      waitDone();
      checkResult("t4", 4'b1101, 1'b0, 7'b0100001);
      repeat (8) tick();
      checkOutput("t4_doneCount", 32'(doneCount), 32'd1);
      checkOutput("t4_idle", 32'(bus.busy), 32'd0);

      // Start held high: back-to-back ops, operands changed after capture.
      applyStimulus(4'd1, 4'd2, 1'b0);
      bus.start = 1'b1;
      bus.a     = 4'd7;
      bus.b     = 4'd1;
      waitDone();
      checkOutput("t5_sum1", 32'(bus.sum), 32'd3);
      checkOutput("t5_lat1", 32'(doneEdge), 32'd5);
      doneEdge = -1;
      waitDone();
      bus.start = 1'b0;
      checkOutput("t5_lat2", 32'(doneEdge), 32'd11);
      checkOutput("t5_sum2", 32'(bus.sum), 32'd8);
      checkOutput("t5_seg2", 32'(bus.seg), 32'(segExp(7'b0000000)));
      repeat (2) tick();

      // Reset in the middle of RUN aborts without a done pulse.
      applyStimulus(4'd9, 4'd9, 1'b0);
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("t6_rstBusy", 32'(bus.busy), 32'd0);
      checkOutput("t6_rstDone", 32'(bus.done), 32'd0);
      checkOutput("t6_rstSum", 32'(bus.sum), 32'd0);
      checkOutput("t6_rstCout", 32'(bus.cout), 32'd0);
      checkOutput("t6_rstSeg", 32'(bus.seg), 32'(segExp(7'b1000000)));
      @(negedge clk);
      rst_n = 1'b1;
      doneCount = 0;
      repeat (4) tick();
      checkOutput("t6_noAbortDone", 32'(doneCount), 32'd0);
      applyStimulus(4'd5, 4'd4, 1'b0);
      waitDone();
      checkResult("t6", 4'b1001, 1'b0, 7'b0010000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
